// File: rtl/rvfi_mem_pkg.sv
// rvfi_mem_pkg
// Shared types and defaults for the RVFI formal-harness memory responder.
// Holds the per-channel state enum, the default parameter values and a
// helper that derives the byte-strobe width from the data width.
// Optional feature macro used by the design files: RVFI_MEM_CONSISTENT_EN.
package rvfi_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memState_e;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MIN_LATENCY = 1;
  localparam int DEF_MAX_STALL   = 4;

  // One write strobe per data byte.
  function automatic int strbW(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/rvfi_mem_channel.sv
// rvfi_mem_channel
// One independent request/response channel of the formal memory responder.
// A request is latched in IDLE, waits a bounded number of cycles in WAIT
// (released early by rand_ready_i once MIN_LATENCY is met, forced at
// MAX_STALL) and is answered with a one-cycle strobe in RESP.
// Ports:
//   clock_i, reset_i   clock, synchronous active-high reset
//   req_valid_i        request pending
//   req_addr_i         request address
//   req_wstrb_i        byte write strobes, all-zero means read
//   req_wdata_i        write data
//   rand_ready_i       free random early-response enable
//   rand_rdata_i       free random read data
//   track_addr_i       symbolic tracked address (only with RVFI_MEM_CONSISTENT_EN)
//   rsp_ready_o        one-cycle response strobe
//   rsp_rdata_o        response data, held until the next response
//   protocol_err_o     sticky requester-protocol violation flag
// Macro RVFI_MEM_CONSISTENT_EN adds a shadow word giving read-after-write
// consistency on track_addr_i.
module rvfi_mem_channel
  import rvfi_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MIN_LATENCY = DEF_MIN_LATENCY,
  parameter int MAX_STALL   = DEF_MAX_STALL,
  localparam int STRB_W     = strbW(DATA_W)
) (
  input  logic              clock_i,
  input  logic              reset_i,
`ifdef RVFI_MEM_CONSISTENT_EN
  input  logic [ADDR_W-1:0] track_addr_i,
`endif
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [STRB_W-1:0] req_wstrb_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic              rand_ready_i,
  input  logic [DATA_W-1:0] rand_rdata_i,
  output logic              rsp_ready_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_LATENCY);
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_STALL);

  memState_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              fire;
  logic              violation;
  logic [DATA_W-1:0] rspData;

  // State and wait counter register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. The counter stops at MAX_STALL, where the response is forced,
  // so it never needs more than $clog2(MAX_STALL+1) bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if ((cnt_q >= MinCnt) && (rand_ready_i || (cnt_q >= MaxCnt))) begin
          state_d = RESP;
          fire    = 1'b1;
        end else if (cnt_q < MaxCnt) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from registers only.
  always_comb begin
    rsp_ready_o    = (state_q == RESP);
    rsp_rdata_o    = rdata_q;
    protocol_err_o = err_q;
  end

  // Once a request is latched the requester must hold it unchanged until the
  // response strobe has been seen.
  assign violation = (state_q != IDLE) &&
                     (!req_valid_i || (req_addr_i != addr_q) || (req_wstrb_i != wstrb_q));

`ifdef RVFI_MEM_CONSISTENT_EN
  logic [DATA_W-1:0] shadow_q;

  // Reads of the tracked address see the shadow word, not free random data.
  always_comb begin
    rspData = '0;
    if (wstrb_q == '0) begin
      rspData = (addr_q == track_addr_i) ? shadow_q : rand_rdata_i;
    end
  end

  // Writes to the tracked address merge strobed bytes on their response cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      shadow_q <= '0;
    end else if ((state_q == RESP) && (wstrb_q != '0) && (addr_q == track_addr_i)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) begin
          shadow_q[b*8 +: 8] <= req_wdata_i[b*8 +: 8];
        end
      end
    end
  end
`else
  logic unusedWdata;
  assign unusedWdata = ^req_wdata_i;

  always_comb begin
    rspData = '0;
    if (wstrb_q == '0) begin
      rspData = rand_rdata_i;
    end
  end
`endif

  // Request latches, response data and sticky error flag. Response data is
  // only replaced on the next WAIT->RESP transition, never cleared in IDLE.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req_valid_i) begin
        addr_q  <= req_addr_i;
        wstrb_q <= req_wstrb_i;
      end
      if (fire) begin
        rdata_q <= rspData;
      end
      if (violation) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvfi_mem_responder.sv
// rvfi_mem_responder
// Formal-harness memory responder placed between a core's memory ports and
// the formal environment. Each of NUM_CH channels (ch0 imem, ch1 dmem by
// convention) runs an independent request/response FSM with bounded random
// latency; random choices arrive on rand_ready_i / rand_rdata_i.
// Ports (per-channel buses are packed, channel 0 in the low slice):
//   clock_i, reset_i   clock, synchronous active-high reset
//   track_addr_i       symbolic tracked address (only with RVFI_MEM_CONSISTENT_EN)
//   req_valid_i        [NUM_CH]             request pending
//   req_addr_i         [NUM_CH*ADDR_W]      request address
//   req_wstrb_i        [NUM_CH*DATA_W/8]    byte write strobes, 0 = read
//   req_wdata_i        [NUM_CH*DATA_W]      write data
//   rand_ready_i       [NUM_CH]             random early-response enable
//   rand_rdata_i       [NUM_CH*DATA_W]      random read data
//   rsp_ready_o        [NUM_CH]             one-cycle response strobe
//   rsp_rdata_o        [NUM_CH*DATA_W]      response data
//   protocol_err_o     [NUM_CH]             sticky protocol violation flag
// Macro RVFI_MEM_CONSISTENT_EN enables read-after-write consistency on
// track_addr_i.
module rvfi_mem_responder
  import rvfi_mem_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MIN_LATENCY = DEF_MIN_LATENCY,
  parameter int MAX_STALL   = DEF_MAX_STALL,
  localparam int STRB_W     = strbW(DATA_W)
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
`ifdef RVFI_MEM_CONSISTENT_EN
  input  logic [ADDR_W-1:0]        track_addr_i,
`endif
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*STRB_W-1:0] req_wstrb_i,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata_i,
  input  logic [NUM_CH-1:0]        rand_ready_i,
  input  logic [NUM_CH*DATA_W-1:0] rand_rdata_i,
  output logic [NUM_CH-1:0]        rsp_ready_o,
  output logic [NUM_CH*DATA_W-1:0] rsp_rdata_o,
  output logic [NUM_CH-1:0]        protocol_err_o
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    rvfi_mem_channel #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .MIN_LATENCY (MIN_LATENCY),
      .MAX_STALL   (MAX_STALL)
    ) u_channel (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
`ifdef RVFI_MEM_CONSISTENT_EN
      .track_addr_i   (track_addr_i),
`endif
      .req_valid_i    (req_valid_i[ch]),
      .req_addr_i     (req_addr_i[ch*ADDR_W +: ADDR_W]),
      .req_wstrb_i    (req_wstrb_i[ch*STRB_W +: STRB_W]),
      .req_wdata_i    (req_wdata_i[ch*DATA_W +: DATA_W]),
      .rand_ready_i   (rand_ready_i[ch]),
      .rand_rdata_i   (rand_rdata_i[ch*DATA_W +: DATA_W]),
      .rsp_ready_o    (rsp_ready_o[ch]),
      .rsp_rdata_o    (rsp_rdata_o[ch*DATA_W +: DATA_W]),
      .protocol_err_o (protocol_err_o[ch])
    );
  end

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// tb_rvfi_mem_responder
// Randomised scoreboard bench for rvfi_mem_responder. Per-channel drivers
// choose a response latency and data for every request, derive the response
// cycle and value from the latency rules, and queue it; a monitor pops and
// compares whenever a response strobe appears.
module tb_rvfi_mem_responder;

  localparam int NUM_CH    = 2;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int STRB_W    = DATA_W / 8;
  localparam int MIN_LAT   = 2;
  localparam int MAX_STALL = 5;
  localparam int N_TRANS   = 60;
  localparam logic [ADDR_W-1:0] TRACK_ADDR = 32'h40;

  typedef struct {
    int                cycle;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic [ADDR_W-1:0]        trackAddr;
  logic [NUM_CH-1:0]        reqValid;
  logic [NUM_CH*ADDR_W-1:0] reqAddr;
  logic [NUM_CH*STRB_W-1:0] reqWstrb;
  logic [NUM_CH*DATA_W-1:0] reqWdata;
  logic [NUM_CH-1:0]        randReady;
  logic [NUM_CH*DATA_W-1:0] randRdata;
  logic [NUM_CH-1:0]        rspReady;
  logic [NUM_CH*DATA_W-1:0] rspRdata;
  logic [NUM_CH-1:0]        protocolErr;

  logic              chValid[NUM_CH];
  logic [ADDR_W-1:0] chAddr[NUM_CH];
  logic [STRB_W-1:0] chWstrb[NUM_CH];
  logic [DATA_W-1:0] chWdata[NUM_CH];
  logic              chRandReady[NUM_CH];
  logic [DATA_W-1:0] chRandRdata[NUM_CH];

  exp_t              expQ[NUM_CH][$];
  exp_t              monItem;
  logic              errModel[NUM_CH];
  logic [DATA_W-1:0] shadowModel[NUM_CH];

  int checks   = 0;
  int failures = 0;
  int cycleNum = 0;

  assign trackAddr = TRACK_ADDR;

  rvfi_mem_responder #(
    .NUM_CH      (NUM_CH),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MIN_LATENCY (MIN_LAT),
    .MAX_STALL   (MAX_STALL)
  ) dut (
    .clock_i        (clock),
    .reset_i        (reset),
`ifdef RVFI_MEM_CONSISTENT_EN
    .track_addr_i   (trackAddr),
`endif
    .req_valid_i    (reqValid),
    .req_addr_i     (reqAddr),
    .req_wstrb_i    (reqWstrb),
    .req_wdata_i    (reqWdata),
    .rand_ready_i   (randReady),
    .rand_rdata_i   (randRdata),
    .rsp_ready_o    (rspReady),
    .rsp_rdata_o    (rspRdata),
    .protocol_err_o (protocolErr)
  );

  always #5 clock = ~clock;

  // Cycle n is the interval following the n-th rising edge.
  always @(posedge clock) cycleNum = cycleNum + 1;

  // Pack the per-channel driver variables onto the DUT buses.
  always_comb begin
    reqValid  = '0;
    reqAddr   = '0;
    reqWstrb  = '0;
    reqWdata  = '0;
    randReady = '0;
    randRdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      reqValid[c]                  = chValid[c];
      reqAddr[c*ADDR_W +: ADDR_W]  = chAddr[c];
      reqWstrb[c*STRB_W +: STRB_W] = chWstrb[c];
      reqWdata[c*DATA_W +: DATA_W] = chWdata[c];
      randReady[c]                 = chRandReady[c];
      randRdata[c*DATA_W +: DATA_W] = chRandRdata[c];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, actual, expected, cycleNum);
    end
  endtask

  // Drive nTrans random requests on one channel. The latency lat is the WAIT
  // count on which the response fires, so the strobe belongs in cycle
  // accept + lat + 1.
  task automatic applyStimulus(input int ch, input int nTrans);
    for (int t = 0; t < nTrans; t++) begin
      logic [ADDR_W-1:0] addr;
      logic [STRB_W-1:0] strb;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] fireData;
      logic [DATA_W-1:0] expData;
      int lat;
      int gap;
      int violate;
      int startCycle;

      case ($urandom_range(0, 3))
        0:       addr = TRACK_ADDR;
        1:       addr = 32'h44;
        2:       addr = 32'h100;
        default: addr = 32'h104;
      endcase
      strb     = ($urandom_range(0, 1) == 1) ? STRB_W'($urandom_range(1, 15)) : '0;
      wdata    = $urandom;
      fireData = $urandom;
      lat      = $urandom_range(MIN_LAT, MAX_STALL);
      violate  = 0;
      if ((t == 5) || ($urandom_range(0, 9) == 0)) violate = $urandom_range(1, 3);

      if (strb != '0) begin
        expData = '0;
      end else begin
        expData = fireData;
`ifdef RVFI_MEM_CONSISTENT_EN
        if (addr == TRACK_ADDR) expData = shadowModel[ch];
`endif
      end
`ifdef RVFI_MEM_CONSISTENT_EN
      if ((strb != '0) && (addr == TRACK_ADDR)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb[b]) shadowModel[ch][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end
`endif
      if (violate != 0) errModel[ch] = 1'b1;

      startCycle = cycleNum;
      expQ[ch].push_back('{cycle: startCycle + lat + 1, data: expData, err: errModel[ch]});

      chValid[ch]     = 1'b1;
      chAddr[ch]      = addr;
      chWstrb[ch]     = strb;
      chWdata[ch]     = wdata;
      chRandReady[ch] = 1'($urandom_range(0, 1));
      chRandRdata[ch] = $urandom;

      for (int k = 1; k <= lat; k++) begin
        @(posedge clock); #1;
        if (k < MIN_LAT)        chRandReady[ch] = 1'($urandom_range(0, 1));
        else if (k < lat)       chRandReady[ch] = 1'b0;
        else if (lat < MAX_STALL) chRandReady[ch] = 1'b1;
        else                    chRandReady[ch] = 1'($urandom_range(0, 1));
        chRandRdata[ch] = (k == lat) ? fireData : DATA_W'($urandom);
        if ((k == 1) && (violate == 1)) chAddr[ch]  = addr ^ 32'h4;
        if ((k == 1) && (violate == 2)) chValid[ch] = 1'b0;
        if ((k == 2) && (violate == 2)) chValid[ch] = 1'b1;
        if ((k == 1) && (violate == 3)) chWstrb[ch] = strb ^ 4'b0001;
      end

      // Response cycle: request held unchanged.
      @(posedge clock); #1;
      chRandReady[ch] = 1'($urandom_range(0, 1));
      chRandRdata[ch] = $urandom;

      // Back in IDLE: either present the next request right away or idle.
      @(posedge clock); #1;
      gap = $urandom_range(0, 2);
      if ((gap > 0) || (t == nTrans - 1)) begin
        chValid[ch] = 1'b0;
        repeat (gap) begin
          @(posedge clock); #1;
        end
      end
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rspReady[c]) begin
        if (expQ[c].size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_rsp ch%0d: got rsp_ready=1 want 0 (cycle %0d)", c, cycleNum);
        end else begin
          monItem = expQ[c].pop_front();
          checkOutput($sformatf("rsp_cycle_ch%0d", c), 64'(cycleNum), 64'(monItem.cycle));
          checkOutput($sformatf("rsp_rdata_ch%0d", c), 64'(rspRdata[c*DATA_W +: DATA_W]), 64'(monItem.data));
          checkOutput($sformatf("rsp_err_ch%0d", c), 64'(protocolErr[c]), 64'(monItem.err));
        end
      end else if ((expQ[c].size() != 0) && (expQ[c][0].cycle <= cycleNum)) begin
        monItem = expQ[c].pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL missing_rsp ch%0d: got rsp_ready=0 want 1 at cycle %0d", c, monItem.cycle);
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cycleNum);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      chValid[c]     = 1'b0;
      chAddr[c]      = '0;
      chWstrb[c]     = '0;
      chWdata[c]     = '0;
      chRandReady[c] = 1'b0;
      chRandRdata[c] = '0;
      errModel[c]    = 1'b0;
      shadowModel[c] = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_rsp_ready", 64'(rspReady), 64'd0);
    checkOutput("reset_rsp_rdata", 64'(rspRdata), 64'd0);
    checkOutput("reset_protocol_err", 64'(protocolErr), 64'd0);
    reset = 1'b0;

    // Reset during WAIT aborts the request without a response.
    @(posedge clock); #1;
    chValid[0]     = 1'b1;
    chAddr[0]      = 32'h100;
    chWstrb[0]     = '0;
    chRandReady[0] = 1'b1;
    chRandRdata[0] = 32'hDEADBEEF;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      checkOutput("abort_rsp_ready", 64'(rspReady), 64'd0);
      checkOutput("abort_rsp_rdata", 64'(rspRdata), 64'd0);
      checkOutput("abort_protocol_err", 64'(protocolErr), 64'd0);
    end
    @(posedge clock); #1;
    reset      = 1'b0;
    chValid[0] = 1'b0;
    @(posedge clock); #1;

    $display("[TB] random phase: %0d transactions per channel", N_TRANS);
    fork
      applyStimulus(0, N_TRANS);
      applyStimulus(1, N_TRANS);
    join
    repeat (4) @(posedge clock);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      checkOutput($sformatf("drain_ch%0d", c), 64'(expQ[c].size()), 64'd0);
      checkOutput($sformatf("err_sticky_ch%0d", c), 64'(protocolErr[c]), 64'(errModel[c]));
    end

    // Reset clears the sticky error and the held response data.
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checkOutput("post_reset_protocol_err", 64'(protocolErr), 64'd0);
    checkOutput("post_reset_rsp_rdata", 64'(rspRdata), 64'd0);
    checkOutput("post_reset_rsp_ready", 64'(rspReady), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
